// File: rtl/trigger_activity_monitor.sv
// trigger_activity_monitor
// Per-channel rising-edge rate counter for the LVDS trigger inputs. Edges are
// counted over a fixed gate window and the totals are snapshotted into read
// registers that the management subsystem can fetch through a simple read port.
// Optional build macro: TRIG_ACTIVITY_STRETCH_EN adds a per-channel retriggerable
// stretch of the activity flag (front-panel LED blink).

module trigger_activity_monitor #(
    parameter int NUM_CH      = 12,
    parameter int CNT_WIDTH   = 32,
    parameter int GATE_CYCLES = 250000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    trig_in,
    input  logic                 rd_en,
    input  logic [3:0]           rd_addr,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 gate_done,
    output logic                 snap_valid,
    output logic [NUM_CH-1:0]    activity
);

    localparam int                   GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0]    GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    logic [NUM_CH-1:0]    sync_meta_q, sync_meta_d;
    logic [NUM_CH-1:0]    sync_q, sync_d;
    logic [NUM_CH-1:0]    sync_dly_q, sync_dly_d;
    logic [NUM_CH-1:0]    edge_det;

    logic [CNT_WIDTH-1:0] live_q [NUM_CH];
    logic [CNT_WIDTH-1:0] live_d [NUM_CH];
    logic [CNT_WIDTH-1:0] live_inc [NUM_CH];
    logic [CNT_WIDTH-1:0] snap_q [NUM_CH];
    logic [CNT_WIDTH-1:0] snap_d [NUM_CH];
    logic [NUM_CH-1:0]    snap_nz_q, snap_nz_d;

    logic [GATE_W-1:0]    gate_cnt_q, gate_cnt_d;
    logic                 tc;
    logic                 gate_done_q, gate_done_d;
    logic                 snap_valid_q, snap_valid_d;

    logic                 rd_valid_q, rd_valid_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

    // Two-flop synchronizer plus a delayed copy feeding the rising-edge detector.
    always_comb begin
        sync_meta_d = trig_in;
        sync_d      = sync_meta_q;
        sync_dly_d  = sync_q;
        edge_det    = sync_q & ~sync_dly_q;
    end

    // Synchronizer register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_q <= '0;
            sync_q      <= '0;
            sync_dly_q  <= '0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            sync_dly_q  <= sync_dly_d;
        end
    end

    // Gate timing and saturating counters; an edge on the terminal cycle still belongs to the ending window.
    always_comb begin
        tc           = (gate_cnt_q == GATE_LAST);
        gate_cnt_d   = tc ? '0 : gate_cnt_q + GATE_W'(1);
        gate_done_d  = tc;
        snap_valid_d = snap_valid_q | tc;
        snap_nz_d    = snap_nz_q;
        for (int i = 0; i < NUM_CH; i++) begin
            live_inc[i] = (edge_det[i] && (live_q[i] != CNT_MAX)) ?
                          live_q[i] + CNT_WIDTH'(1) : live_q[i];
            live_d[i]   = tc ? '0 : live_inc[i];
            snap_d[i]   = tc ? live_inc[i] : snap_q[i];
            if (tc) begin
                snap_nz_d[i] = (live_inc[i] != '0);
            end
        end
    end

    // Gate, live-count and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_cnt_q   <= '0;
            gate_done_q  <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_nz_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            gate_cnt_q   <= gate_cnt_d;
            gate_done_q  <= gate_done_d;
            snap_valid_q <= snap_valid_d;
            snap_nz_q    <= snap_nz_d;
            for (int i = 0; i < NUM_CH; i++) begin
                live_q[i] <= live_d[i];
                snap_q[i] <= snap_d[i];
            end
        end
    end

    // Read mux; it samples the snapshot before any same-edge update and returns zero for unmapped addresses.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (rd_addr == 4'(i)) begin
                    rd_data_d = snap_q[i];
                end
            end
        end
    end

    // Read response registers; rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

`ifdef TRIG_ACTIVITY_STRETCH_EN
    logic [21:0] stretch_q [NUM_CH];
    logic [21:0] stretch_d [NUM_CH];

    // Retriggerable down-counters that keep the activity flag lit for about 2^22 cycles after each edge.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (edge_det[i]) begin
                stretch_d[i] = '1;
            end else if (stretch_q[i] != '0) begin
                stretch_d[i] = stretch_q[i] - 22'd1;
            end else begin
                stretch_d[i] = '0;
            end
        end
    end

    // Stretch counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                stretch_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                stretch_q[i] <= stretch_d[i];
            end
        end
    end

    // Activity combines the last snapshot status with the LED stretch.
    always_comb begin
        activity = snap_nz_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (stretch_q[i] != '0) begin
                activity[i] = 1'b1;
            end
        end
    end
`else
    assign activity = snap_nz_q;
`endif

    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign gate_done  = gate_done_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_trigger_activity_monitor.sv
// Testbench for trigger_activity_monitor: directed trigger patterns, read
// expectations queued at issue time and checked by an independent monitor.

module tb_trigger_activity_monitor;

    localparam int NUM_CH      = 12;
    localparam int CNT_WIDTH   = 8;
    localparam int GATE_CYCLES = 1000;

    typedef struct {
        int          cyc;
        logic [11:0] act;
    } gate_exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_CH-1:0]    trig_in = '0;
    logic                 rd_en = 1'b0;
    logic [3:0]           rd_addr = '0;
    logic                 rd_valid;
    logic [CNT_WIDTH-1:0] rd_data;
    logic                 gate_done;
    logic                 snap_valid;
    logic [NUM_CH-1:0]    activity;

    int checks   = 0;
    int failures = 0;
    int edge_idx = -1;

    logic [CNT_WIDTH-1:0] exp_q[$];
    string                tag_q[$];
    gate_exp_t            gate_q[$];

    trigger_activity_monitor #(
        .NUM_CH      (NUM_CH),
        .CNT_WIDTH   (CNT_WIDTH),
        .GATE_CYCLES (GATE_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .trig_in    (trig_in),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .gate_done  (gate_done),
        .snap_valid (snap_valid),
        .activity   (activity)
    );

    always #5 clk = ~clk;

    // Index of the most recent rising clock edge since reset release.
    always @(posedge clk or posedge rst) begin
        if (rst) edge_idx <= -1;
        else     edge_idx <= edge_idx + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Trigger waveform per phase and edge index.
    function automatic logic [11:0] trig_pattern(input int ph, input int k);
        logic [11:0] p = '0;
        if (ph == 1) begin
            if (k >= 10   && k < 750  && ((k - 10)   % 20) < 10) p[3] = 1'b1;
            if (k >= 1010 && k < 1210 && ((k - 1010) % 20) < 10) p[3] = 1'b1;
            if (k >= 1200 && k < 1800 && ((k - 1200) % 2) == 0)  p[5] = 1'b1;
            if (k >= 1996 && k < 2010)                           p[0] = 1'b1;
            if (k >= 2100 && k < 2200 && ((k - 2100) % 40) < 10) p[7] = 1'b1;
            if (k >= 3100 && k < 3130 && ((k - 3100) % 20) < 10) p[7] = 1'b1;
        end else begin
            if (k >= 200 && k < 210) p[1] = 1'b1;
        end
        return p;
    endfunction

    // Read vectors with hand-computed expected snapshots.
    function automatic void read_vec(input int ph, input int k, output bit en,
                                     output logic [3:0] addr, output logic [7:0] exp,
                                     output string tag);
        en = 1'b1; addr = '0; exp = '0; tag = "";
        if (ph == 1) begin
            case (k)
                100:     begin addr = 3;  exp = 0;   tag = "pre_gate_ch3";   end
                1005:    begin addr = 3;  exp = 37;  tag = "win0_ch3";       end
                1006:    begin addr = 13; exp = 0;   tag = "addr13";         end
                1007:    begin addr = 0;  exp = 0;   tag = "win0_ch0";       end
                1008:    begin addr = 5;  exp = 0;   tag = "win0_ch5";       end
                1998:    begin addr = 3;  exp = 37;  tag = "tc_read_old";    end
                1999:    begin addr = 3;  exp = 10;  tag = "win1_ch3";       end
                2000:    begin addr = 0;  exp = 1;   tag = "win1_ch0_tc";    end
                2001:    begin addr = 5;  exp = 255; tag = "win1_ch5_sat";   end
                2002:    begin addr = 14; exp = 0;   tag = "addr14";         end
                2003:    begin addr = 3;  exp = 10;  tag = "win1_ch3_again"; end
                3005:    begin addr = 0;  exp = 0;   tag = "win2_ch0_clear"; end
                3006:    begin addr = 3;  exp = 0;   tag = "win2_ch3";       end
                3007:    begin addr = 7;  exp = 3;   tag = "win2_ch7";       end
                default: en = 1'b0;
            endcase
        end else begin
            case (k)
                300:     begin addr = 1; exp = 0; tag = "rst_pre_gate_ch1"; end
                1003:    begin addr = 1; exp = 1; tag = "rst_win0_ch1";     end
                1004:    begin addr = 7; exp = 0; tag = "rst_win0_ch7";     end
                default: en = 1'b0;
            endcase
        end
    endfunction

    task automatic applyStimulus(input int ph, input int kmax);
        bit          en;
        logic [3:0]  addr;
        logic [7:0]  exp;
        string       tag;
        for (int k = 0; k <= kmax; k++) begin
            @(posedge clk);
            #1;
            trig_in = trig_pattern(ph, k);
            read_vec(ph, k, en, addr, exp, tag);
            rd_en   = en;
            rd_addr = addr;
            if (en) begin
                exp_q.push_back(exp);
                tag_q.push_back(tag);
            end
            if (ph == 1 && k == 100)  checkOutput("snap_valid_pre_gate", 32'(snap_valid), 0);
            if (ph == 1 && k == 1005) checkOutput("snap_valid_after_gate", 32'(snap_valid), 1);
            if (ph == 1 && k == 2010) begin
                checkOutput("rd_valid_idle", 32'(rd_valid), 0);
                checkOutput("rd_data_hold", 32'(rd_data), 10);
            end
            if (ph == 2 && k == 300)  checkOutput("snap_valid_after_rst", 32'(snap_valid), 0);
        end
        rd_en   = 1'b0;
        trig_in = '0;
    endtask

    // Scoreboard monitor: pops expectations whenever the DUT presents a read or a gate pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL rd_unexpected actual=rd_valid expected=no_read");
                end else begin
                    checkOutput(tag_q.pop_front(), 32'(rd_data), 32'(exp_q.pop_front()));
                end
            end
            if (gate_done) begin
                if (gate_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL gate_unexpected actual=%0d expected=no_gate", edge_idx);
                end else begin
                    gate_exp_t g;
                    g = gate_q.pop_front();
                    checkOutput("gate_cycle", 32'(edge_idx), 32'(g.cyc));
                    checkOutput("gate_activity", 32'(activity), 32'(g.act));
                    checkOutput("gate_snap_valid", 32'(snap_valid), 1);
                end
            end
        end
    end

    initial begin
        $display("[TB] start");
        gate_q.push_back('{cyc: 999,  act: 12'h008});
        gate_q.push_back('{cyc: 1999, act: 12'h029});
        gate_q.push_back('{cyc: 2999, act: 12'h080});
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rd_valid", 32'(rd_valid), 0);
        checkOutput("reset_snap_valid", 32'(snap_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1, 3500);

        // Reset mid-window with edges pending on ch7.
        rst = 1'b1;
        #1;
        checkOutput("rst_activity", 32'(activity), 0);
        checkOutput("rst_snap_valid", 32'(snap_valid), 0);
        checkOutput("rst_rd_data", 32'(rd_data), 0);
        checkOutput("rst_rd_valid", 32'(rd_valid), 0);
        checkOutput("rst_gate_done", 32'(gate_done), 0);
        repeat (3) @(posedge clk);
        gate_q.push_back('{cyc: 999, act: 12'h002});
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(2, 1010);

        repeat (5) @(negedge clk);
        checkOutput("rd_queue_drained", 32'(exp_q.size()), 0);
        checkOutput("gate_queue_drained", 32'(gate_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
